// File: rtl/alu_result_stage.sv
// alu_result_stage: execute-to-writeback stage behind the ALU.
// Holds results in a 2-entry skid buffer, keeps the {N,Z,C,V} status
// register and resolves conditional branches against it.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid / in_ready      producer handshake (ALU side)
//   alu_f, alu_cout, alu_v,  ALU result and flag outputs
//   alu_z
//   in_dest                  destination register address
//   set_flags                update status register on accept
//   is_branch, cond          conditional branch and its condition code
//   out_valid / out_ready    consumer handshake (writeback / PC select)
//   out_data, out_dest       head entry result and destination
//   out_we, out_taken        head is a write / head is a taken branch
//   flags                    status register {N,Z,C,V}
//   count                    buffer occupancy 0..2
module alu_result_stage #(
    parameter int n = 4,
    parameter int r = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] alu_f,
    input  logic         alu_cout,
    input  logic         alu_v,
    input  logic         alu_z,
    input  logic [r-1:0] in_dest,
    input  logic         set_flags,
    input  logic         is_branch,
    input  logic [2:0]   cond,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_data,
    output logic [r-1:0] out_dest,
    output logic         out_we,
    output logic         out_taken,
    output logic [3:0]   flags,
    output logic [1:0]   count
);

    typedef struct packed {
        logic [n-1:0] data;
        logic [r-1:0] dest;
        logic         we;
        logic         taken;
    } entry_t;

    entry_t     head_q;
    entry_t     tail_q;
    entry_t     new_e;
    logic [1:0] count_q;
    logic [3:0] flags_q;
    logic       accept;
    logic       pop;
    logic       cond_hit;
    logic       flag_upd;

    logic f_n;
    logic f_z;
    logic f_c;
    logic f_v;

    // Ready comes only from registered occupancy, so no
    // combinational path from out_ready back to in_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign flag_upd  = accept & set_flags & ~is_branch;

    assign f_n = flags_q[3];
    assign f_z = flags_q[2];
    assign f_c = flags_q[1];
    assign f_v = flags_q[0];

    // Branches resolve against the flags held before this edge,
    // so a flag-setting op directly ahead is already visible.
    always_comb begin
        cond_hit = 1'b0;
        unique case (cond)
            3'b000: cond_hit = 1'b1;
            3'b001: cond_hit = f_z;
            3'b010: cond_hit = ~f_z;
            3'b011: cond_hit = f_c;
            3'b100: cond_hit = ~f_c;
            3'b101: cond_hit = f_n;
            3'b110: cond_hit = f_v;
            3'b111: cond_hit = 1'b0;
        endcase
    end

    always_comb begin
        new_e       = '0;
        new_e.data  = alu_f;
        new_e.dest  = in_dest;
        new_e.we    = ~is_branch;
        new_e.taken = is_branch & cond_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else if (flag_upd) begin
            flags_q <= {alu_f[n-1], alu_z, alu_cout, alu_v};
        end
    end

    // head_q is always the oldest entry; tail_q only matters
    // while two entries are held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            unique case (1'b1)
                accept & ~pop: begin
                    if (count_q == 2'd0) begin
                        head_q <= new_e;
                    end else begin
                        tail_q <= new_e;
                    end
                    count_q <= count_q + 2'd1;
                end
                accept & pop: begin
                    // only reachable at count 1
                    head_q <= new_e;
                end
                ~accept & pop: begin
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                    end
                    count_q <= count_q - 2'd1;
                end
                default: begin
                    count_q <= count_q;
                end
            endcase
        end
    end

    assign out_data  = head_q.data;
    assign out_dest  = head_q.dest;
    assign out_we    = head_q.we;
    assign out_taken = head_q.taken;
    assign flags     = flags_q;
    assign count     = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed plus random checks of alu_result_stage
// against a queue-based reference model.
module tb_alu_result_stage;

    localparam int N = 4;
    localparam int R = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] alu_f;
    logic         alu_cout;
    logic         alu_v;
    logic         alu_z;
    logic [R-1:0] in_dest;
    logic         set_flags;
    logic         is_branch;
    logic [2:0]   cond;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [R-1:0] out_dest;
    logic         out_we;
    logic         out_taken;
    logic [3:0]   flags;
    logic [1:0]   count;

    alu_result_stage #(.n(N), .r(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_f     (alu_f),
        .alu_cout  (alu_cout),
        .alu_v     (alu_v),
        .alu_z     (alu_z),
        .in_dest   (in_dest),
        .set_flags (set_flags),
        .is_branch (is_branch),
        .cond      (cond),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dest  (out_dest),
        .out_we    (out_we),
        .out_taken (out_taken),
        .flags     (flags),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        logic [R-1:0] dest;
        logic         we;
        logic         taken;
    } m_t;

    m_t         mq[$];
    logic [3:0] mflags;
    logic       last_acc;
    int         total;
    int         bad;

    function automatic logic resolve(input logic [2:0] c,
                                     input logic [3:0] fl);
        logic [7:0] tbl;
        // index = condition code; fl = {N,Z,C,V}
        tbl = {1'b0, fl[0], fl[3], ~fl[1], fl[1], ~fl[2], fl[2], 1'b1};
        return tbl[c];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mflags   = 4'b0000;
        last_acc = 1'b0;
    endtask

    task automatic model_step();
        bit acc;
        bit pp;
        m_t e;
        acc = in_valid && (mq.size() != 2);
        pp  = (mq.size() != 0) && out_ready;
        if (pp) void'(mq.pop_front());
        if (acc) begin
            e.data  = alu_f;
            e.dest  = in_dest;
            e.we    = !is_branch;
            e.taken = is_branch ? resolve(cond, mflags) : 1'b0;
            mq.push_back(e);
            if (set_flags && !is_branch)
                mflags = {alu_f[N-1], alu_z, alu_cout, alu_v};
        end
        last_acc = acc;
    endtask

    task automatic check_all();
        chk("count", count, mq.size());
        chk("out_valid", out_valid, mq.size() != 0);
        chk("in_ready", in_ready, mq.size() != 2);
        chk("flags", flags, mflags);
        if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0].data);
            chk("out_dest", out_dest, mq[0].dest);
            chk("out_we", out_we, mq[0].we);
            chk("out_taken", out_taken, mq[0].taken);
        end
    endtask

    // Inputs are driven at the falling edge; one call advances a cycle
    // and checks outputs at the next falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [N-1:0] f,
                         input logic co, input logic ov, input logic z,
                         input logic [R-1:0] d, input logic sf,
                         input logic br, input logic [2:0] c);
        in_valid  = v;
        alu_f     = f;
        alu_cout  = co;
        alu_v     = ov;
        alu_z     = z;
        in_dest   = d;
        set_flags = sf;
        is_branch = br;
        cond      = c;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        logic [7:0] sweep_exp;
        int         waited;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        out_ready = 1'b0;
        idle();
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_flags", flags, 0);
        chk("rst_data", out_data, 0);
        chk("rst_dest", out_dest, 0);
        chk("rst_we", out_we, 0);
        chk("rst_taken", out_taken, 0);
        rst = 1'b0;

        // single op
        drive(1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 3'b000);
        cycle();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8);
        chk("single_dest", out_dest, 2);
        chk("single_we", out_we, 1);
        chk("single_flags", flags, 4'b1011);
        idle();
        out_ready = 1'b1;
        cycle();

        // back-pressure and fill
        out_ready = 1'b0;
        drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b000);
        cycle();
        drive(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 3'b000);
        cycle();
        drive(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 3'b000);
        cycle();
        chk("fill_count", count, 2);
        chk("fill_ready", in_ready, 0);
        chk("fill_head", out_data, 5);
        out_ready = 1'b1;
        waited = 0;
        do begin
            cycle();
            waited++;
        end while (!last_acc && waited < 4);
        chk("fill_third_accepted", last_acc, 1);
        idle();
        repeat (3) cycle();
        chk("drain_empty", count, 0);

        // simultaneous push/pop at count 1
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000);
            cycle();
            chk("pp_count", count, 1);
            chk("pp_data", out_data, i);
        end
        idle();
        cycle();

        // branch resolution against prior flags
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 3'b000);
        cycle();
        drive(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 3'b001);
        cycle();
        chk("br_z_taken", out_taken, 1);
        chk("br_z_we", out_we, 0);
        chk("br_flags_kept", flags, 4'b0100);
        drive(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 3'b010);
        cycle();
        chk("br_nz_taken", out_taken, 0);
        chk("br_flags_kept2", flags, 4'b0100);
        idle();
        cycle();

        // async reset mid-operation
        out_ready = 1'b0;
        drive(1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 3'b000);
        cycle();
        cycle();
        chk("pre_rst_count", count, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_flags", flags, 0);
        chk("arst_ready", in_ready, 1);
        cycle();
        rst = 1'b0;
        idle();
        cycle();
        chk("post_rst_flags", flags, 0);

        // condition sweep with N=1 Z=0 C=1 V=0
        out_ready = 1'b1;
        drive(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 3'b000);
        cycle();
        chk("sweep_flags", flags, 4'b1010);
        sweep_exp = 8'b0010_1101;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 2'($urandom), 1'b1, 1'b1, 3'(c));
            cycle();
            chk("sweep_taken", out_taken, sweep_exp[c]);
        end
        idle();
        cycle();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                  3'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            cycle();
        end

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
